// File: rtl/dbg_link_pkg.sv
// Shared types and protocol constants for the host-to-BRAM debug link.
package dbg_link_pkg;

  typedef enum logic [3:0] {
    IDLE, H_TGT, H_CNT0, H_CNT1,
    LD_BYTE, LD_WR, LD_CSUM,
    DP_ADDR, DP_WAIT, DP_SEND, DP_CSUM,
    ACK, ERR
  } linkState_t;

  typedef struct packed {
    logic [31:0] a2;
    logic [31:0] wd2;
    logic [3:0]  we2;
  } portReq_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_ERR  = 8'h15;
  localparam logic [7:0] TGT_DATA = 8'h00;
  localparam logic [7:0] TGT_INST = 8'h01;

  function automatic logic [31:0] byteAddr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/dbg_port_mux.sv
// Steers the link's BRAM request to the selected debug port; the other port sees all zeros.
module dbg_port_mux
  import dbg_link_pkg::*;
(
  input  logic        instSel,
  input  portReq_t    req,
  output portReq_t    dataReq,
  output portReq_t    instReq,
  input  logic [31:0] dataRd,
  input  logic [31:0] instRd,
  output logic [31:0] rd
);

  assign dataReq = instSel ? '0  : req;
  assign instReq = instSel ? req : '0;
  assign rd      = instSel ? instRd : dataRd;

endmodule

// File: rtl/dbg_ram_link.sv
// Host byte-stream loader/dumper for the RV32Core instruction and data BRAM debug ports.
// Optional DBG_RAM_LINK_CHECKSUM_EN adds an XOR-of-data byte after load and dump payloads.
module dbg_ram_link
  import dbg_link_pkg::*;
#(
  parameter int BRAM_WORDS = 4096,
  parameter int RD_LAT     = 1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_hold,
  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2,
  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2
);

  localparam int AW = $clog2(BRAM_WORDS);
`ifdef DBG_RAM_LINK_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [16:0] MAX_CNT = 17'(BRAM_WORDS);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [1:0]  LAT_M1  = 2'(RD_LAT - 1);

  linkState_t  state, stateNext;
  logic        isLoad, tgtSel;
  logic [7:0]  cntLo, csum;
  logic [AW:0] cntReg, wordIdx;
  logic [1:0]  byteIdx, waitCnt;
  logic [31:0] wordBuf, rdSel, curAddr;
  logic [16:0] cntFull;
  logic        rxFire, txFire, lastWord, lastByte;
  portReq_t    req, dataReq, instReq;

  assign rxFire   = rx_valid & rx_ready;
  assign txFire   = tx_valid & tx_ready;
  assign lastWord = (wordIdx + ONE) == cntReg;
  assign lastByte = byteIdx == 2'd3;
  assign cntFull  = {1'b0, rx_data, cntLo};
  assign curAddr  = byteAddr(30'(wordIdx[AW-1:0]));
  assign cpu_hold = state != IDLE;

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req       = '0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid)
          stateNext = (rx_data == CMD_LOAD || rx_data == CMD_DUMP) ? H_TGT : ERR;
      end
      H_TGT: begin
        rx_ready = 1'b1;
        if (rx_valid)
          stateNext = (rx_data == TGT_DATA || rx_data == TGT_INST) ? H_CNT0 : ERR;
      end
      H_CNT0: begin
        rx_ready = 1'b1;
        if (rx_valid) stateNext = H_CNT1;
      end
      H_CNT1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (cntFull > MAX_CNT)      stateNext = ERR;
          else if (cntFull == 17'd0)  stateNext = ACK;
          else                        stateNext = isLoad ? LD_BYTE : DP_ADDR;
        end
      end
      LD_BYTE: begin
        rx_ready = 1'b1;
        if (rx_valid && lastByte) stateNext = LD_WR;
      end
      LD_WR: begin
        req.a2  = curAddr;
        req.wd2 = wordBuf;
        req.we2 = 4'hF;
        if (!lastWord)    stateNext = LD_BYTE;
        else if (CSUM_EN) stateNext = LD_CSUM;
        else              stateNext = ACK;
      end
      LD_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) stateNext = (rx_data == csum) ? ACK : ERR;
      end
      DP_ADDR: begin
        req.a2    = curAddr;
        stateNext = DP_WAIT;
      end
      DP_WAIT: begin
        req.a2 = curAddr;
        if (waitCnt == 2'd0) stateNext = DP_SEND;
      end
      DP_SEND: begin
        tx_valid = 1'b1;
        tx_data  = wordBuf[7:0];
        if (tx_ready && lastByte) begin
          if (!lastWord)    stateNext = DP_ADDR;
          else if (CSUM_EN) stateNext = DP_CSUM;
          else              stateNext = ACK;
        end
      end
      DP_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) stateNext = ACK;
      end
      ACK: begin
        tx_valid = 1'b1;
        tx_data  = RSP_ACK;
        if (tx_ready) stateNext = IDLE;
      end
      ERR: begin
        tx_valid = 1'b1;
        tx_data  = RSP_ERR;
        if (tx_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Word buffer shifts right: load fills from the top so the first byte lands in [7:0],
  // dump drains from the bottom so the first byte sent is [7:0].
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST) begin
      isLoad  <= 1'b0;
      tgtSel  <= 1'b0;
      cntLo   <= 8'h00;
      cntReg  <= '0;
      wordIdx <= '0;
      byteIdx <= 2'd0;
      waitCnt <= 2'd0;
      wordBuf <= 32'h0;
      csum    <= 8'h00;
    end else begin
      case (state)
        IDLE: if (rxFire) begin
          isLoad  <= rx_data == CMD_LOAD;
          wordIdx <= '0;
          byteIdx <= 2'd0;
          csum    <= 8'h00;
        end
        H_TGT:  if (rxFire) tgtSel <= rx_data == TGT_INST;
        H_CNT0: if (rxFire) cntLo  <= rx_data;
        H_CNT1: if (rxFire) cntReg <= cntFull[AW:0];
        LD_BYTE: if (rxFire) begin
          wordBuf <= {rx_data, wordBuf[31:8]};
          csum    <= csum ^ rx_data;
          byteIdx <= byteIdx + 2'd1;
        end
        LD_WR:   wordIdx <= wordIdx + ONE;
        DP_ADDR: waitCnt <= LAT_M1;
        DP_WAIT: begin
          if (waitCnt == 2'd0) begin
            wordBuf <= rdSel;
            byteIdx <= 2'd0;
          end else begin
            waitCnt <= waitCnt - 2'd1;
          end
        end
        DP_SEND: if (txFire) begin
          wordBuf <= {8'h00, wordBuf[31:8]};
          csum    <= csum ^ wordBuf[7:0];
          byteIdx <= byteIdx + 2'd1;
          if (lastByte) wordIdx <= wordIdx + ONE;
        end
        default: ;
      endcase
    end
  end

  dbg_port_mux uMux (
    .instSel (tgtSel),
    .req     (req),
    .dataReq (dataReq),
    .instReq (instReq),
    .dataRd  (CPU_Debug_DataRAM_RD2),
    .instRd  (CPU_Debug_InstRAM_RD2),
    .rd      (rdSel)
  );

  assign CPU_Debug_DataRAM_A2  = dataReq.a2;
  assign CPU_Debug_DataRAM_WD2 = dataReq.wd2;
  assign CPU_Debug_DataRAM_WE2 = dataReq.we2;
  assign CPU_Debug_InstRAM_A2  = instReq.a2;
  assign CPU_Debug_InstRAM_WD2 = instReq.wd2;
  assign CPU_Debug_InstRAM_WE2 = instReq.we2;

endmodule

// File: tb/tb_dbg_ram_link.sv
// Randomized bench for dbg_ram_link: host frames in, BRAM writes and tx bytes compared to a frame-level model.
`timescale 1ns/1ps
module tb_dbg_ram_link;
  import dbg_link_pkg::*;

  localparam int WORDS = 4096;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cpu_hold;
  logic [31:0] dA2, dWD2, dRD2, iA2, iWD2, iRD2;
  logic [3:0]  dWE2, iWE2;

  always #5 CPU_CLK = ~CPU_CLK;

  dbg_ram_link #(.BRAM_WORDS(WORDS), .RD_LAT(1)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_hold(cpu_hold),
    .CPU_Debug_DataRAM_A2(dA2), .CPU_Debug_DataRAM_WD2(dWD2),
    .CPU_Debug_DataRAM_WE2(dWE2), .CPU_Debug_DataRAM_RD2(dRD2),
    .CPU_Debug_InstRAM_A2(iA2), .CPU_Debug_InstRAM_WD2(iWD2),
    .CPU_Debug_InstRAM_WE2(iWE2), .CPU_Debug_InstRAM_RD2(iRD2)
  );

  // BRAMs with one-cycle registered read
  logic [31:0] dmem [WORDS];
  logic [31:0] imem [WORDS];
  initial for (int i = 0; i < WORDS; i++) begin dmem[i] = 32'h0; imem[i] = 32'h0; end
  always @(posedge CPU_CLK) begin
    if (dWE2 == 4'hF) dmem[dA2[13:2]] <= dWD2;
    if (iWE2 == 4'hF) imem[iA2[13:2]] <= iWD2;
    dRD2 <= dmem[dA2[13:2]];
    iRD2 <= imem[iA2[13:2]];
  end

  typedef struct {
    logic        inst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } wr_t;

  int          nChecks = 0;
  int          nErrors = 0;
  wr_t         wrLog[$];
  wr_t         expWr[$];
  logic [7:0]  txLog[$];
  logic [7:0]  expTx[$];
  logic [7:0]  frameQ[$];
  logic [31:0] model [2][WORDS];
  int          holdDrops = 0;
  bit          holdWatch = 0;
  bit          stallPrev = 0;
  logic [7:0]  stallData = 8'h00;
  int          txMode = 0;

  initial for (int i = 0; i < WORDS; i++) begin model[0][i] = 32'h0; model[1][i] = 32'h0; end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Host side: tx_ready pattern per mode (0 always, 1 toggle, 2 random)
  always @(posedge CPU_CLK) begin
    #1;
    case (txMode)
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b1;
    endcase
  end

  // Monitor: sampled mid-cycle, one sample per clock
  always @(negedge CPU_CLK) begin
    if (dWE2 != 4'h0) wrLog.push_back('{1'b0, dA2, dWD2, dWE2});
    if (iWE2 != 4'h0) wrLog.push_back('{1'b1, iA2, iWD2, iWE2});
    if (tx_valid && tx_ready) txLog.push_back(tx_data);
    if (holdWatch && !cpu_hold) holdDrops++;
    if (tx_valid) chk("rx_blocked", 32'(rx_ready), 32'd0);
    if (stallPrev) begin
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'(stallData));
    end
    stallPrev = tx_valid && !tx_ready;
    stallData = tx_data;
  end

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 2000) begin tick(); guard++; end
    if (!rx_ready) chk("rx_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  function automatic logic [7:0] xorWord(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  function automatic void hdr(input logic [7:0] cmd, input bit inst, input int n);
    frameQ.delete(); expTx.delete(); expWr.delete();
    frameQ.push_back(cmd);
    frameQ.push_back({7'd0, inst});
    frameQ.push_back(8'(n));
    frameQ.push_back(8'(n >> 8));
  endfunction

  // Load: words land at 4*i of the chosen BRAM; reply ACK (ERR on a bad checksum)
  function automatic void buildLoad(input bit inst, input int n, input logic [31:0] words[$], input bit badCsum);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    hdr(CMD_LOAD, inst, n);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) frameQ.push_back(8'(w >> (8*k)));
      cs ^= xorWord(w);
      expWr.push_back('{inst, 32'(4*i), w, 4'hF});
      model[inst][i] = w;
    end
`ifdef DBG_RAM_LINK_CHECKSUM_EN
    frameQ.push_back(badCsum ? cs ^ 8'h01 : cs);
    expTx.push_back(badCsum ? RSP_ERR : RSP_ACK);
`else
    expTx.push_back(badCsum ? RSP_ACK : RSP_ACK);
`endif
  endfunction

  function automatic void buildDump(input bit inst, input int n);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    hdr(CMD_DUMP, inst, n);
    for (int i = 0; i < n; i++) begin
      w = model[inst][i];
      for (int k = 0; k < 4; k++) expTx.push_back(8'(w >> (8*k)));
      cs ^= xorWord(w);
    end
`ifdef DBG_RAM_LINK_CHECKSUM_EN
    if (n > 0) expTx.push_back(cs);
`endif
    expTx.push_back(RSP_ACK);
  endfunction

  task automatic runFrame(input string tag, input int budget);
    int g = 0;
    txLog.delete(); wrLog.delete(); holdDrops = 0;
    foreach (frameQ[i]) begin
      sendByte(frameQ[i]);
      if (i == 0) holdWatch = 1;
    end
    do begin tick(); g++; end while (txLog.size() < expTx.size() && g < budget);
    holdWatch = 0;
    repeat (2) tick();
    chk({tag, "_txn"}, 32'(txLog.size()), 32'(expTx.size()));
    for (int i = 0; i < txLog.size() && i < expTx.size(); i++)
      chk({tag, "_tx"}, 32'(txLog[i]), 32'(expTx[i]));
    chk({tag, "_wrn"}, 32'(wrLog.size()), 32'(expWr.size()));
    for (int i = 0; i < wrLog.size() && i < expWr.size(); i++) begin
      chk({tag, "_wtgt"}, 32'(wrLog[i].inst), 32'(expWr[i].inst));
      chk({tag, "_waddr"}, wrLog[i].addr, expWr[i].addr);
      chk({tag, "_wdata"}, wrLog[i].data, expWr[i].data);
      chk({tag, "_wwe"}, 32'(wrLog[i].we), 32'(expWr[i].we));
    end
    chk({tag, "_hold_end"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_hold_drop"}, 32'(holdDrops), 32'd0);
    chk({tag, "_rxrdy"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_rxrdy"}, 32'(rx_ready), 32'd1);
    chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_da2"}, dA2, 32'd0);
    chk({tag, "_dwd"}, dWD2, 32'd0);
    chk({tag, "_dwe"}, 32'(dWE2), 32'd0);
    chk({tag, "_ia2"}, iA2, 32'd0);
    chk({tag, "_iwe"}, 32'(iWE2), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ws[$];
    int n;
    bit inst;

    repeat (3) tick();
    chkResetOutputs("reset");
    CPU_RST = 1'b1;
    tick();

    ws = '{32'h12345678, 32'hDEADBEEF};
    buildLoad(1'b0, 2, ws, 1'b0);
    runFrame("load2", 200);

    ws = '{32'h00000013};
    buildLoad(1'b1, 1, ws, 1'b0);
    runFrame("load_inst", 200);
    txMode = 1;
    buildDump(1'b1, 1);
    runFrame("dump_inst", 400);
    txMode = 0;

    frameQ = '{8'h41}; expTx = '{RSP_ERR}; expWr.delete();
    runFrame("bad_cmd", 100);
    frameQ = '{CMD_LOAD, 8'h02}; expTx = '{RSP_ERR}; expWr.delete();
    runFrame("bad_tgt", 100);
    frameQ = '{CMD_DUMP, 8'h00, 8'h01, 8'h10}; expTx = '{RSP_ERR}; expWr.delete();
    runFrame("bad_cnt", 100);
    frameQ = '{CMD_LOAD, 8'h01, 8'h00, 8'h00}; expTx = '{RSP_ACK}; expWr.delete();
    runFrame("cnt0", 100);

    // Abort a load two bytes into its first word
    txLog.delete(); wrLog.delete();
    frameQ = '{CMD_LOAD, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (frameQ[i]) sendByte(frameQ[i]);
    CPU_RST = 1'b0;
    tick();
    chkResetOutputs("midrst");
    CPU_RST = 1'b1;
    repeat (4) tick();
    chk("midrst_wrn", 32'(wrLog.size()), 32'd0);
    chk("midrst_txn", 32'(txLog.size()), 32'd0);
    ws = '{$urandom()};
    buildLoad(1'b0, 1, ws, 1'b0);
    runFrame("after_rst", 200);

    for (int it = 0; it < 6; it++) begin
      n    = $urandom_range(1, 8);
      inst = 1'($urandom_range(0, 1));
      ws.delete();
      for (int i = 0; i < n; i++) ws.push_back($urandom());
      txMode = $urandom_range(0, 2);
      buildLoad(inst, n, ws, 1'b0);
      runFrame("rnd_load", 400);
      txMode = $urandom_range(0, 2);
      buildDump(inst, $urandom_range(1, 10));
      runFrame("rnd_dump", 1000);
    end
    txMode = 0;

`ifdef DBG_RAM_LINK_CHECKSUM_EN
    frameQ = '{CMD_LOAD, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    expTx = '{RSP_ACK}; expWr = '{'{1'b0, 32'h0, 32'h04030201, 4'hF}};
    model[0][0] = 32'h04030201;
    runFrame("csum_ok", 200);
    frameQ = '{CMD_LOAD, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expTx = '{RSP_ERR};
    runFrame("csum_bad", 200);
    buildDump(1'b0, 1);
    runFrame("csum_dump", 200);
`endif

    ws.delete();
    for (int i = 0; i < WORDS; i++) ws.push_back(32'(i));
    buildLoad(1'b0, WORDS, ws, 1'b0);
    runFrame("full_load", 2000);
    if (wrLog.size() > 0) chk("full_last_addr", wrLog[wrLog.size()-1].addr, 32'h3FFC);
    else                  chk("full_last_addr", 32'(wrLog.size()), 32'd4096);
    buildDump(1'b0, WORDS);
    runFrame("full_dump", 40000);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/dbg_ram_link.md
Name: dbg_ram_link

Overview:
- Synthesizable on-board counterpart to the simulation loader/dumper. Drives the instruction and data BRAM debug ports (A2/WD2/WE2/RD2) of RV32Core from a host byte stream, e.g. a UART bridge.
- Host commands either load N words into a BRAM from address 0, or dump N words back out.
- Holds the core in reset while a command is active, so the board can be reprogrammed and inspected without re-synthesis.

Parameters:
- BRAM_WORDS, 4096: words per BRAM; the largest legal count.
- RD_LAT, 1: cycles from A2 change to RD2 valid; legal range 1..3.

Ports:
- CPU_CLK  in  1  system clock; all logic on rising edge.
- CPU_RST  in  1  reset; synchronous, active-low.
- rx_data  in  8  host byte in.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts byte (valid&ready = transfer).
- tx_data  out  8  byte to host.
- tx_valid  out  1  tx_data valid; held stable until accepted.
- tx_ready  in  1  host accepts byte.
- cpu_hold  out  1  high = keep core in reset.
- CPU_Debug_DataRAM_A2  out  32  data BRAM byte address.
- CPU_Debug_DataRAM_WD2  out  32  data BRAM write data.
- CPU_Debug_DataRAM_WE2  out  4  data BRAM byte enables.
- CPU_Debug_DataRAM_RD2  in  32  data BRAM read data.
- CPU_Debug_InstRAM_A2/WD2/WE2/RD2: same widths and meaning, instruction BRAM.

Behaviour:
- Reset (CPU_RST=0 at an edge): state IDLE; all outputs 0 except rx_ready=1; counters cleared. Reset mid-command aborts it: no partial write completes after the reset edge, and no tx byte is emitted.
- Frame format: CMD, TGT, CNT_LO, CNT_HI.
  - CMD: 0x4C 'L' = load, 0x44 'D' = dump.
  - TGT: 0 = data BRAM, 1 = instruction BRAM.
  - CNT: 16-bit word count.
- States: IDLE → H_TGT → H_CNT0 → H_CNT1, then LD_BYTE/LD_WR for load, DP_ADDR/DP_WAIT/DP_SEND for dump, then ACK or ERR → IDLE.
- Header checks:
  - CMD not 'L'/'D' in IDLE → ERR.
  - TGT > 1 → ERR.
  - CNT > BRAM_WORDS → ERR.
  - CNT = 0 → ACK with no BRAM access.
- cpu_hold rises the cycle after CMD is accepted. It falls on the cycle ACK/ERR is accepted.
- Load:
  - rx_ready=1 in LD_BYTE; bytes are assembled little-endian (first byte = WD2[7:0]).
  - After the 4th byte, LD_WR lasts exactly 1 cycle: A2 = 4*word_idx, WE2 = 4'hF, WD2 = word; rx_ready=0.
  - word_idx increments; returns to LD_BYTE or, after the last word, ACK.
  - WE2 is 0 in every other cycle. The non-selected BRAM's WE2 is always 0.
- Dump:
  - DP_ADDR drives A2 = 4*word_idx.
  - DP_WAIT lasts RD_LAT cycles, then RD2 is latched.
  - DP_SEND emits 4 bytes little-endian, each held until tx_ready.
  - Next word follows, or ACK after the last word.
  - rx_ready=0 throughout the dump.
- ACK: tx_data = 0x06. ERR: tx_data = 0x15. Each is held with tx_valid until accepted.
- Addresses are 12-bit word index × 4, zero-extended to 32 bits; no wrap is possible because CNT ≤ BRAM_WORDS.
- rx_ready=0 whenever tx_valid=1; input is never consumed while output is pending.
- Idle A2 = 0.

Optional Feature:
- Macro: DBG_RAM_LINK_CHECKSUM_EN.
- Enabled, load: after the last data byte the block expects one XOR-of-all-data-bytes byte.
  - Mismatch → ERR. Words already written stay written.
- Enabled, dump: the XOR byte is sent after the last data byte, before ACK.
- Disabled: no checksum byte in either direction.

Decomposition:
- Package dbg_link_pkg holds:
  - state enum;
  - CMD_LOAD = 8'h4C, CMD_DUMP = 8'h44, RSP_ACK = 8'h06, RSP_ERR = 8'h15;
  - TGT_DATA = 0, TGT_INST = 1.
- Sub-module dbg_port_mux: steers A2/WD2/WE2 to the selected BRAM and zeroes the other; selects the matching RD2.
- FSM and byte assembler stay in the top.

Test Plan:
- Load data BRAM: 'L',0,2,0, bytes 78 56 34 12 EF BE AD DE → WE2 = F at A2 = 0 with WD2 = 12345678, then at A2 = 4 with WD2 = DEADBEEF; inst WE2 = 0 throughout; ACK 06.
- Dump inst BRAM after loading 00000013 at word 0, count 1 → tx bytes 13 00 00 00 then 06; tx_ready toggled 1/0 each cycle, bytes unchanged while stalled.
- Errors:
  - CMD 0x41 → 15, with no BRAM activity and cpu_hold back to 0.
  - TGT 2 → 15.
  - CNT 0x1001 → 15.
  - CNT 0 → 06 with no writes.
- Reset mid-load, asserted after 2 of 4 bytes → no WE2 pulse; outputs at reset values. A fresh frame then works.
- Full-range load of 4096 words (data[i] = i) then dump → last write A2 = 0x3FFC; dumped stream equals the input; cpu_hold high for the whole transfer.
- DBG_RAM_LINK_CHECKSUM_EN:
  - Load 1 word 01 02 03 04 with checksum 04 → 06.
  - Same load with checksum 05 → 15.
  - Dump appends the XOR byte before 06.
